// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI read burst engine.
// The state encoding, the 4 KB boundary and the arsize helper live here so the top and bench agree.
package axi_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    localparam int unsigned BOUNDARY_4K = 4096;

    function automatic logic [2:0] arsize_from_width(input int unsigned width);
        return 3'($clog2(width / 8));
    endfunction

endpackage

// File: rtl/axi_skid_buf.sv
// Two-entry skid buffer between the AXI R channel and the output stream.
// Output is registered, so a beat appears one cycle after it is accepted.
module axi_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             aclk,
    input  logic             reset_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign wr_ready = (count != 2'd2);
    assign rd_valid = (count != 2'd0);
    assign empty    = (count == 2'd0);
    assign rd_data  = mem[rd_ptr];
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;

    always_ff @(posedge aclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/axi_rd_burst_engine.sv
// Splits a beat-count read command into AXI INCR bursts (length cap, 4 KB split,
// outstanding limit) and streams the returned data out through a skid buffer.
module axi_rd_burst_engine
    import axi_rd_pkg::*;
#(
    parameter int AXI_DATA_WIDTH  = 128,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int MAX_BURST_LEN   = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                      aclk,
    input  logic                      reset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]      cmd_beats,
    output logic [AXI_DATA_WIDTH-1:0] rd_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic                      rd_last,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic [3:0]                m_axi_arid,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic [3:0]                m_axi_rid
);

    localparam int                  BYTES     = AXI_DATA_WIDTH / 8;
    localparam int                  SIZE_LOG2 = $clog2(BYTES);
    localparam logic [2:0]          SIZE      = arsize_from_width(AXI_DATA_WIDTH);
    localparam int                  OW        = $clog2(MAX_OUTSTANDING + 1);
    localparam int                  CW        = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = AXI_ADDR_WIDTH'(BYTES - 1);

    // State table
    //   state    | meaning
    //   ST_IDLE  | waiting for a command, cmd_ready high
    //   ST_ISSUE | issuing AR bursts until all beats are requested
    //   ST_DRAIN | all ARs issued, waiting for rlast of each and an empty skid
    //   ST_DONE  | one-cycle completion pulse

    logic [1:0] rst_ff;
    logic       rst_n;

    always_ff @(posedge aclk or negedge reset_n) begin
        if (!reset_n) rst_ff <= 2'b00;
        else          rst_ff <= {rst_ff[0], 1'b1};
    end
    assign rst_n = rst_ff[1];

    rd_state_e                 state, state_nxt;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]      remaining;
    logic [LEN_WIDTH-1:0]      rx_left;
    logic [OW-1:0]             outstanding;
    logic                      err_q;

    logic [12:0]   bytes_to_bound;
    logic [12:0]   beats_to_bound;
    logic [CW-1:0] len_w;
    logic          ar_valid;
    logic          ar_hs;
    logic          last_ar;
    logic          cmd_acc;
    logic          r_acc;
    logic          rlast_acc;
    logic          skid_empty;
    logic          skid_last;
    logic          unused_rid;

    assign unused_rid = ^m_axi_rid;

    assign bytes_to_bound = 13'(BOUNDARY_4K) - {1'b0, addr_q[11:0]};
    assign beats_to_bound = bytes_to_bound >> SIZE_LOG2;

    always_comb begin
        len_w = CW'(remaining);
        if (CW'(MAX_BURST_LEN) < len_w) len_w = CW'(MAX_BURST_LEN);
        if (CW'(beats_to_bound) < len_w) len_w = CW'(beats_to_bound);
    end

    // ARVALID is derived from registers only, so address and length hold until arready.
    assign ar_valid  = (state == ST_ISSUE) && (outstanding < OW'(MAX_OUTSTANDING))
                       && (remaining != '0);
    assign ar_hs     = ar_valid && m_axi_arready;
    assign last_ar   = ar_hs && (CW'(remaining) == len_w);
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign r_acc     = m_axi_rvalid && m_axi_rready;
    assign rlast_acc = r_acc && m_axi_rlast;

    assign m_axi_arvalid = ar_valid;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = ar_valid ? 8'(len_w - CW'(1)) : 8'd0;
    assign m_axi_arsize  = SIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arid    = 4'd0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'd0;
    assign err           = err_q;

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cmd_acc) state_nxt = (cmd_beats == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (last_ar) state_nxt = ST_DRAIN;
            ST_DRAIN: if ((outstanding == '0) && skid_empty) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = rst_n;
                busy      = 1'b0;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            remaining   <= '0;
            rx_left     <= '0;
            outstanding <= '0;
            err_q       <= 1'b0;
        end else begin
            if (cmd_acc) begin
                addr_q    <= cmd_addr & ~ALIGN_MASK;
                remaining <= cmd_beats;
                rx_left   <= cmd_beats;
                err_q     <= 1'b0;
            end else begin
                if (ar_hs) begin
                    addr_q    <= addr_q + (AXI_ADDR_WIDTH'(len_w) << SIZE_LOG2);
                    remaining <= remaining - LEN_WIDTH'(len_w);
                end
                if (r_acc) begin
                    rx_left <= rx_left - LEN_WIDTH'(1);
                    if (m_axi_rresp != 2'b00) err_q <= 1'b1;
                end
            end
            case ({ar_hs, rlast_acc})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // The command-level last flag is computed from the beat count, so intermediate rlast never leaks.
    axi_skid_buf #(
        .WIDTH (AXI_DATA_WIDTH + 1)
    ) u_skid (
        .aclk     (aclk),
        .reset_n  (rst_n),
        .wr_valid (m_axi_rvalid),
        .wr_ready (m_axi_rready),
        .wr_data  ({(rx_left == LEN_WIDTH'(1)), m_axi_rdata}),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  ({skid_last, rd_data}),
        .empty    (skid_empty)
    );

    assign rd_last = rd_valid && skid_last;

endmodule

// File: tb/tb_axi_rd_burst_engine.sv
// Directed bench for axi_rd_burst_engine with a behavioural AXI read slave.
module tb_axi_rd_burst_engine;

    logic         aclk;
    logic         reset_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  cmd_addr;
    logic [15:0]  cmd_beats;
    logic [127:0] rd_data;
    logic         rd_valid;
    logic         rd_ready;
    logic         rd_last;
    logic         busy;
    logic         done;
    logic         err;
    logic         m_axi_arvalid;
    logic         m_axi_arready;
    logic [31:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic [3:0]   m_axi_arid;
    logic [3:0]   m_axi_arcache;
    logic [2:0]   m_axi_arprot;
    logic         m_axi_rvalid;
    logic         m_axi_rready;
    logic [127:0] m_axi_rdata;
    logic [1:0]   m_axi_rresp;
    logic         m_axi_rlast;
    logic [3:0]   m_axi_rid;

    int checks = 0;
    int errors = 0;

    axi_rd_burst_engine dut (
        .aclk          (aclk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_beats     (cmd_beats),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_last       (rd_last),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arid    (m_axi_arid),
        .m_axi_arcache (m_axi_arcache),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rid     (m_axi_rid)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    function automatic logic [127:0] pat(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, 32'h1234_5678};
    endfunction

    // Slave and stream monitor state
    logic [31:0]  ar_q_addr[$];
    logic [7:0]   ar_q_len[$];
    logic [31:0]  ar_log_addr[$];
    logic [7:0]   ar_log_len[$];
    logic [127:0] rd_log_data[$];
    logic         rd_log_last[$];
    bit           r_hold = 0;
    bit           rd_rand = 0;
    bit           slv_flush = 0;
    int           err_at = 0;
    int           beats_acc = 0;
    int           done_cnt = 0;
    bit           cur_active = 0;
    logic [31:0]  cur_addr = '0;
    logic [7:0]   cur_len = '0;
    int           beat_i = 0;

    // Everything is sampled and driven on the falling edge; *_p holds what the next rising edge sees.
    initial begin
        logic         arv_p, arr_p, rdv_p, rdr_p, rdl_p, rr_p;
        logic [31:0]  araddr_p;
        logic [7:0]   arlen_p;
        logic [127:0] rdd_p;
        arv_p = 0; arr_p = 0; rdv_p = 0; rdr_p = 0; rdl_p = 0; rr_p = 0;
        araddr_p = '0; arlen_p = '0; rdd_p = '0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axi_rlast = 0; m_axi_rid = 4'd0; rd_ready = 0;
        forever begin
            @(negedge aclk);
            if (arv_p && arr_p) begin
                ar_q_addr.push_back(araddr_p);
                ar_q_len.push_back(arlen_p);
                ar_log_addr.push_back(araddr_p);
                ar_log_len.push_back(arlen_p);
            end
            if (rdv_p && rdr_p) begin
                rd_log_data.push_back(rdd_p);
                rd_log_last.push_back(rdl_p);
            end
            if (m_axi_rvalid && rr_p) begin
                beats_acc++;
                if (m_axi_rlast) cur_active = 0;
                else beat_i++;
            end
            if (slv_flush) begin
                ar_q_addr.delete();
                ar_q_len.delete();
                cur_active = 0;
                arv_p = 0;
                rdv_p = 0;
                slv_flush = 0;
            end
            if (!cur_active && ar_q_addr.size() > 0 && !r_hold) begin
                cur_addr = ar_q_addr.pop_front();
                cur_len = ar_q_len.pop_front();
                cur_active = 1;
                beat_i = 0;
            end
            m_axi_rvalid = cur_active && !r_hold;
            m_axi_rdata = pat(cur_addr + 32'(beat_i * 16));
            m_axi_rlast = (beat_i == int'(cur_len));
            m_axi_rresp = (err_at != 0 && beats_acc + 1 == err_at) ? 2'b10 : 2'b00;
            m_axi_arready = 1;
            rd_ready = rd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done) done_cnt++;
            arv_p = m_axi_arvalid;
            araddr_p = m_axi_araddr;
            arlen_p = m_axi_arlen;
            arr_p = m_axi_arready;
            rdv_p = rd_valid;
            rdd_p = rd_data;
            rdl_p = rd_last;
            rdr_p = rd_ready;
            rr_p = m_axi_rready;
        end
    end

    task automatic start_cmd(input logic [31:0] a, input logic [15:0] n);
        int t = 0;
        while (!cmd_ready && t < 200) begin
            @(negedge aclk);
            t++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL start_cmd: cmd_ready=%b required 1 within 200 cycles", cmd_ready);
        end
        ar_log_addr.delete();
        ar_log_len.delete();
        rd_log_data.delete();
        rd_log_last.delete();
        beats_acc = 0;
        cmd_valid = 1;
        cmd_addr = a;
        cmd_beats = n;
        @(negedge aclk);
        cmd_valid = 0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int t = 0; t < budget; t++) begin
            if (done) begin
                ok = 1;
                break;
            end
            @(negedge aclk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_done: done not seen within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (3) @(negedge aclk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", m_axi_arvalid); end
        checks++; if (m_axi_araddr !== 32'h0) begin errors++; $display("FAIL reset_araddr: got %h want 0", m_axi_araddr); end
        checks++; if (m_axi_arlen !== 8'h0) begin errors++; $display("FAIL reset_arlen: got %h want 0", m_axi_arlen); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last: got %b want 0", rd_last); end
        reset_n = 1;
        repeat (4) @(negedge aclk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        checks++;
        if (m_axi_arsize !== 3'd4 || m_axi_arburst !== 2'b01 || m_axi_arid !== 4'd0
            || m_axi_arcache !== 4'b0011 || m_axi_arprot !== 3'd0) begin
            errors++;
            $display("FAIL ar_const: size=%0d burst=%b id=%0d cache=%b prot=%0d want 4 01 0 0011 0",
                     m_axi_arsize, m_axi_arburst, m_axi_arid, m_axi_arcache, m_axi_arprot);
        end
    endtask

    task automatic test_split_bursts();
        logic [31:0] ea[3] = '{32'h1000, 32'h1100, 32'h1200};
        logic [7:0]  el[3] = '{8'd15, 8'd15, 8'd7};
        int bad = 0;
        int d0;
        bit ok;
        start_cmd(32'h0000_1000, 16'd40);
        d0 = done_cnt;
        wait_done(500, ok);
        repeat (6) @(negedge aclk);
        checks++;
        if (ar_log_addr.size() != 3) begin
            errors++;
            $display("FAIL split_ar_count: got %0d want 3", ar_log_addr.size());
        end else begin
            for (int i = 0; i < 3; i++)
                if (ar_log_addr[i] !== ea[i] || ar_log_len[i] !== el[i]) bad++;
            if (bad != 0) begin
                errors++;
                $display("FAIL split_ar_list: got %h/%0d %h/%0d %h/%0d want 1000/15 1100/15 1200/7",
                         ar_log_addr[0], ar_log_len[0], ar_log_addr[1], ar_log_len[1],
                         ar_log_addr[2], ar_log_len[2]);
            end
        end
        checks++;
        bad = 0;
        if (rd_log_data.size() != 40) begin
            errors++;
            $display("FAIL split_beats: got %0d beats want 40", rd_log_data.size());
        end else begin
            for (int k = 0; k < 40; k++)
                if (rd_log_data[k] !== pat(32'h1000 + 32'(k * 16)) || rd_log_last[k] !== (k == 39)) bad++;
            if (bad != 0) begin
                errors++;
                $display("FAIL split_data: %0d beats wrong in data or rd_last, want 0", bad);
            end
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL split_done_pulses: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_4k_split();
        int bad = 0;
        bit ok;
        start_cmd(32'h0000_0FC0, 16'd8);
        wait_done(200, ok);
        @(negedge aclk);
        checks++;
        if (ar_log_addr.size() != 2 || ar_log_addr[0] !== 32'h0FC0 || ar_log_len[0] !== 8'd3
            || ar_log_addr[1] !== 32'h1000 || ar_log_len[1] !== 8'd3) begin
            errors++;
            $display("FAIL split4k_ar: count=%0d first=%h/%0d want 2 bursts 0fc0/3 1000/3",
                     ar_log_addr.size(), ar_log_addr.size() > 0 ? ar_log_addr[0] : 32'hx,
                     ar_log_len.size() > 0 ? ar_log_len[0] : 8'hx);
        end
        checks++;
        if (rd_log_data.size() != 8) begin
            errors++;
            $display("FAIL split4k_beats: got %0d want 8", rd_log_data.size());
        end else begin
            for (int k = 0; k < 8; k++)
                if (rd_log_data[k] !== pat(32'h0FC0 + 32'(k * 16)) || rd_log_last[k] !== (k == 7)) bad++;
            if (bad != 0) begin
                errors++;
                $display("FAIL split4k_data: %0d beats wrong, want 0", bad);
            end
        end
        start_cmd(32'h0000_3005, 16'd1);
        wait_done(200, ok);
        @(negedge aclk);
        checks++;
        if (ar_log_addr.size() != 1 || ar_log_addr[0] !== 32'h3000 || ar_log_len[0] !== 8'd0
            || rd_log_data.size() != 1 || rd_log_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL align_single: ar_count=%0d beats=%0d want 1 burst at 3000 len 0 and 1 last beat",
                     ar_log_addr.size(), rd_log_data.size());
        end
    endtask

    task automatic test_outstanding();
        logic [7:0] el[7] = '{8'd15, 8'd15, 8'd15, 8'd15, 8'd15, 8'd15, 8'd3};
        int bad = 0;
        bit ok;
        r_hold = 1;
        start_cmd(32'h0000_2000, 16'd100);
        repeat (30) @(negedge aclk);
        checks++;
        if (ar_log_addr.size() != 4) begin
            errors++;
            $display("FAIL outst_ar_count: got %0d want 4", ar_log_addr.size());
        end
        checks++;
        if (m_axi_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL outst_arvalid: got %b want 0 with 4 outstanding", m_axi_arvalid);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL outst_busy: got %b want 1", busy);
        end
        r_hold = 0;
        wait_done(1000, ok);
        @(negedge aclk);
        checks++;
        if (ar_log_addr.size() != 7) begin
            errors++;
            $display("FAIL outst_total_ar: got %0d want 7", ar_log_addr.size());
        end else begin
            for (int i = 0; i < 7; i++)
                if (ar_log_addr[i] !== 32'h2000 + 32'(i * 256) || ar_log_len[i] !== el[i]) bad++;
            if (bad != 0) begin
                errors++;
                $display("FAIL outst_ar_list: %0d bursts wrong, want 0", bad);
            end
        end
        checks++;
        bad = 0;
        if (rd_log_data.size() != 100) begin
            errors++;
            $display("FAIL outst_beats: got %0d want 100", rd_log_data.size());
        end else begin
            for (int k = 0; k < 100; k++)
                if (rd_log_data[k] !== pat(32'h2000 + 32'(k * 16)) || rd_log_last[k] !== (k == 99)) bad++;
            if (bad != 0) begin
                errors++;
                $display("FAIL outst_data: %0d beats wrong, want 0", bad);
            end
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        bit ok;
        rd_rand = 1;
        start_cmd(32'h0000_5000, 16'd64);
        wait_done(2000, ok);
        rd_rand = 0;
        @(negedge aclk);
        checks++;
        if (rd_log_data.size() != 64) begin
            errors++;
            $display("FAIL bp_beats: got %0d want 64", rd_log_data.size());
        end else begin
            for (int k = 0; k < 64; k++)
                if (rd_log_data[k] !== pat(32'h5000 + 32'(k * 16)) || rd_log_last[k] !== (k == 63)) bad++;
            if (bad != 0) begin
                errors++;
                $display("FAIL bp_data: %0d beats wrong, want 0", bad);
            end
        end
    endtask

    task automatic test_err_and_zero();
        int bad = 0;
        int ar0;
        bit ok;
        err_at = 5;
        start_cmd(32'h0000_6000, 16'd20);
        wait_done(500, ok);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_at_done: got %b want 1", err);
        end
        err_at = 0;
        repeat (2) @(negedge aclk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky_idle: got %b want 1", err);
        end
        checks++;
        if (rd_log_data.size() != 20) begin
            errors++;
            $display("FAIL err_beats: got %0d want 20", rd_log_data.size());
        end else begin
            for (int k = 0; k < 20; k++)
                if (rd_log_data[k] !== pat(32'h6000 + 32'(k * 16))) bad++;
            if (bad != 0) begin
                errors++;
                $display("FAIL err_data: %0d beats wrong, want 0", bad);
            end
        end
        start_cmd(32'h0000_7000, 16'd0);
        ar0 = ar_log_addr.size();
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b err=%b want done=1 err=0 one cycle after accept", done, err);
        end
        @(negedge aclk);
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_pulse: done=%b cmd_ready=%b want 0 and 1", done, cmd_ready);
        end
        repeat (3) @(negedge aclk);
        checks++;
        if (ar_log_addr.size() != 0 || ar0 != 0 || rd_log_data.size() != 0) begin
            errors++;
            $display("FAIL zero_no_traffic: ar=%0d beats=%0d want 0 0", ar_log_addr.size(), rd_log_data.size());
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        bit ok;
        r_hold = 1;
        start_cmd(32'h0000_7000, 16'd40);
        repeat (10) @(negedge aclk);
        checks++;
        if (busy !== 1'b1 || ar_log_addr.size() != 3) begin
            errors++;
            $display("FAIL mid_drain_setup: busy=%b ar=%0d want 1 and 3", busy, ar_log_addr.size());
        end
        #2;
        reset_n = 0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || m_axi_arvalid !== 1'b0
            || rd_valid !== 1'b0 || rd_last !== 1'b0 || m_axi_araddr !== 32'h0 || m_axi_arlen !== 8'h0) begin
            errors++;
            $display("FAIL mid_async_reset: busy=%b done=%b err=%b arvalid=%b rd_valid=%b araddr=%h want all 0",
                     busy, done, err, m_axi_arvalid, rd_valid, m_axi_araddr);
        end
        slv_flush = 1;
        r_hold = 0;
        repeat (3) @(negedge aclk);
        reset_n = 1;
        repeat (4) @(negedge aclk);
        start_cmd(32'h0000_8000, 16'd16);
        wait_done(300, ok);
        @(negedge aclk);
        checks++;
        if (ar_log_addr.size() != 1 || ar_log_addr[0] !== 32'h8000 || ar_log_len[0] !== 8'd15) begin
            errors++;
            $display("FAIL mid_next_ar: count=%0d want 1 burst 8000/15", ar_log_addr.size());
        end
        checks++;
        if (rd_log_data.size() != 16) begin
            errors++;
            $display("FAIL mid_next_beats: got %0d want 16", rd_log_data.size());
        end else begin
            for (int k = 0; k < 16; k++)
                if (rd_log_data[k] !== pat(32'h8000 + 32'(k * 16)) || rd_log_last[k] !== (k == 15)) bad++;
            if (bad != 0) begin
                errors++;
                $display("FAIL mid_next_data: %0d beats wrong, want 0", bad);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0;
        cmd_valid = 0;
        cmd_addr = '0;
        cmd_beats = '0;
        test_reset();
        test_split_bursts();
        test_4k_split();
        test_outstanding();
        test_backpressure();
        test_err_and_zero();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_burst_engine.md
AXI_RD_BURST_ENGINE -- requirements
Module: axi_rd_burst_engine

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 128, AXI data width; legal values 32/64/128/256/512.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter MAX_BURST_LEN, default 16, maximum beats per AXI burst (1..256).
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, maximum AR bursts awaiting rlast (1..16).
REQ-005 SHALL have parameter LEN_WIDTH, default 16, width of the command beat count.
REQ-006 SHALL have ports: aclk in 1, clock; reset_n in 1, reset (asynchronous, active-low).
REQ-007 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_addr in AXI_ADDR_WIDTH, start byte address; cmd_beats in LEN_WIDTH, total beats.
REQ-008 SHALL have stream ports: rd_data out AXI_DATA_WIDTH; rd_valid out 1; rd_ready in 1; rd_last out 1, final beat of the command.
REQ-009 SHALL have status ports: busy out 1; done out 1, one-cycle pulse; err out 1, sticky per command.
REQ-010 SHALL have AR ports: m_axi_arvalid out 1; m_axi_arready in 1; m_axi_araddr out AXI_ADDR_WIDTH; m_axi_arlen out 8; m_axi_arsize out 3; m_axi_arburst out 2; m_axi_arid out 4; m_axi_arcache out 4; m_axi_arprot out 3.
REQ-011 SHALL have R ports: m_axi_rvalid in 1; m_axi_rready out 1; m_axi_rdata in AXI_DATA_WIDTH; m_axi_rresp in 2; m_axi_rlast in 1; m_axi_rid in 4.

Function
REQ-012 SHALL use states IDLE, ISSUE, DRAIN, DONE; cmd_ready=1 only in IDLE; busy=1 in any state except IDLE.
REQ-013 Command accept (cmd_valid&&cmd_ready): IDLE->ISSUE; latch address with low log2(AXI_DATA_WIDTH/8) bits forced 0; remaining=cmd_beats; clear err.
REQ-014 cmd_beats==0: IDLE->DONE directly, no AR issued, no data beats.
REQ-015 Burst length = min(remaining, MAX_BURST_LEN, beats to next 4 KB boundary); m_axi_arlen = length-1.
REQ-016 ARVALID rises in ISSUE when outstanding<MAX_OUTSTANDING; araddr/arlen held stable until arready; on handshake address advances by length*bytes, remaining decrements by length.
REQ-017 Constant AR fields: arburst=2'b01 (INCR), arsize=log2(AXI_DATA_WIDTH/8), arid=0, arcache=4'b0011, arprot=0.
REQ-018 ISSUE->DRAIN on the AR handshake that takes remaining to 0.
REQ-019 Outstanding counter: +1 per AR handshake, -1 per R beat accepted with rlast; both same cycle -> unchanged; never exceeds MAX_OUTSTANDING.
REQ-020 R beats SHALL pass through a 2-entry skid buffer; m_axi_rready = skid not full; rd_ready low SHALL stall without data loss or duplication.
REQ-021 Latency m_axi_rvalid to rd_valid: 1 cycle when skid empty and rd_ready=1; full throughput 1 beat/cycle sustained.
REQ-022 rd_last=1 only on the final beat of the final burst; AXI rlast of intermediate bursts is not forwarded.
REQ-023 err SHALL set on any accepted beat with rresp!=2'b00 and hold until next command accept; data still forwarded.
REQ-024 DRAIN->DONE when outstanding==0 and skid empty; DONE->IDLE next cycle; done=1 only in DONE.
REQ-025 cmd_valid while busy SHALL be ignored (cmd_ready=0); rid is ignored.

Reset
REQ-026 reset_n SHALL assert asynchronously and deassert through a 2-flop synchroniser on aclk.
REQ-027 Reset values: state IDLE, cmd_ready 1 after deassert, busy 0, done 0, err 0, m_axi_arvalid 0, araddr 0, arlen 0, rd_valid 0, rd_last 0, outstanding 0, skid empty.
REQ-028 Reset mid-command SHALL abandon all in-flight bursts; no AXI state kept.

Structure
REQ-029 Shared package axi_rd_pkg SHALL hold the state enum, 4 KB boundary constant, and arsize-from-width function.
REQ-030 The skid buffer SHALL be sub-module axi_skid_buf (parameter WIDTH); all else in one module.

Verification
REQ-031 cmd_addr=0x0000_1000, cmd_beats=40, MAX_BURST_LEN=16 -> arlen 15,15,7 at 0x1000,0x1100,0x1200; 40 beats; rd_last on beat 40; one done.
REQ-032 cmd_addr=0x0000_0FC0, cmd_beats=8, 128-bit -> bursts arlen 3 @0x0FC0 and arlen 3 @0x1000 (4 KB split).
REQ-033 arready held 1, slave delays all R data, 100 beats -> arvalid drops after 4 outstanding until first rlast.
REQ-034 rd_ready toggled 1-0 random, 64 beats -> output sequence equals input sequence, no loss/duplicate.
REQ-035 rresp=2'b10 on beat 5 of 20 -> err=1 at done, cleared on next cmd accept; cmd_beats=0 -> done pulse 1 cycle after accept, no AR.
REQ-036 reset_n low during DRAIN -> all outputs at reset values asynchronously; next command completes normally.
